// File: rtl/pc_fetch.sv
`default_nettype none
// ============================================================================
// pc_fetch : instruction-fetch stage; owns the PC, one read in flight on a
//            req/ack/rvalid bus, presents {if_pc, if_inst} to IF/ID.
// Revision : 1.0
// ============================================================================
module pc_fetch #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  stall,
   input  logic        branch_flag_i,
   input  logic [31:0] branch_target,
   input  logic        flush_i,
   input  logic [31:0] new_pc_i,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_ack,
   input  logic        inst_rvalid,
   input  logic [31:0] inst_rdata,
   output logic [31:0] if_pc,
   output logic [31:0] if_inst,
   output logic        stallreq
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_VALID = 2'd2,
      S_DROP  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic        pend_br_q, pend_br_d;
   logic [31:0] br_tgt_q, br_tgt_d;
   logic [31:0] inst_buf_q, inst_buf_d;
   logic        req_en_q;
   logic        req_w;
   logic        valid_w;
   logic [31:0] next_pc_w;
   logic        stall_unused_w;

   // Only bit 0 of the ctrl stall vector concerns this stage.
   assign stall_unused_w = &{1'b0, stall[5:1]};

   // req_en_q keeps inst_req low during reset and until the first edge after release.
   assign req_w     = req_en_q && (state_q == S_REQ);
   assign valid_w   = (state_q == S_VALID);
   assign inst_req  = req_w;
   assign inst_addr = pc_q;
   assign if_pc     = valid_w ? pc_q : 32'd0;
   assign if_inst   = valid_w ? inst_buf_q : 32'd0;
   assign stallreq  = !valid_w;

   // A branch resolved in the same cycle as the delay slot leaves takes effect directly.
   assign next_pc_w = branch_flag_i ? branch_target :
                      (pend_br_q ? br_tgt_q : pc_q + 32'd4);

   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_br_d  = pend_br_q;
      br_tgt_d   = br_tgt_q;
      inst_buf_d = inst_buf_q;

      if (branch_flag_i) begin
         pend_br_d = 1'b1;
         br_tgt_d  = branch_target;
      end

      if (flush_i) begin
         pc_d      = new_pc_i;
         pend_br_d = 1'b0;
         case (state_q)
            S_REQ:   state_d = (req_w && inst_ack) ? S_DROP : S_REQ;
            S_WAIT:  state_d = inst_rvalid ? S_REQ : S_DROP;
            // A read is still outstanding until its rvalid is seen.
            S_DROP:  state_d = inst_rvalid ? S_REQ : S_DROP;
            default: state_d = S_REQ;
         endcase
      end else begin
         case (state_q)
            S_REQ: begin
               if (req_w && inst_ack) state_d = S_WAIT;
            end
            S_WAIT: begin
               if (inst_rvalid) begin
                  inst_buf_d = inst_rdata;
                  state_d    = S_VALID;
               end
            end
            S_VALID: begin
               if (!stall[0]) begin
                  pc_d      = next_pc_w;
                  pend_br_d = 1'b0;
                  state_d   = S_REQ;
               end
            end
            S_DROP: begin
               if (inst_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_REQ;
         pc_q       <= RESET_PC;
         pend_br_q  <= 1'b0;
         br_tgt_q   <= 32'd0;
         inst_buf_q <= 32'd0;
         req_en_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_br_q  <= pend_br_d;
         br_tgt_q   <= br_tgt_d;
         inst_buf_q <= inst_buf_d;
         req_en_q   <= 1'b1;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch.sv
`default_nettype none
// ============================================================================
// tb_pc_fetch : directed self-checking bench for pc_fetch with a simple bus responder.
// Revision    : 1.0
// ============================================================================
module tb_pc_fetch;

   logic        clk;
   logic        rst;
   logic [5:0]  stall;
   logic        branch_flag_i;
   logic [31:0] branch_target;
   logic        flush_i;
   logic [31:0] new_pc_i;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_ack;
   logic        inst_rvalid;
   logic [31:0] inst_rdata;
   logic [31:0] if_pc;
   logic [31:0] if_inst;
   logic        stallreq;

   logic        ack_en;
   logic        rand_mode;
   int          bus_delay;
   logic        use_override;
   logic [31:0] override_data;
   int          bus_cnt;
   logic [31:0] bus_data;

   int checks;
   int errors;

   pc_fetch #(.RESET_PC(32'h0000_0000)) dut (
      .clk           (clk),
      .rst           (rst),
      .stall         (stall),
      .branch_flag_i (branch_flag_i),
      .branch_target (branch_target),
      .flush_i       (flush_i),
      .new_pc_i      (new_pc_i),
      .inst_req      (inst_req),
      .inst_addr     (inst_addr),
      .inst_ack      (inst_ack),
      .inst_rvalid   (inst_rvalid),
      .inst_rdata    (inst_rdata),
      .if_pc         (if_pc),
      .if_inst       (if_inst),
      .stallreq      (stallreq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign inst_ack = ack_en & inst_req;

   // Bus responder: rvalid appears bus_delay cycles after the handshake cycle; data = address unless overridden.
   initial begin
      inst_rvalid = 1'b0;
      inst_rdata  = 32'd0;
      bus_cnt     = 0;
      bus_data    = 32'd0;
   end

   always @(negedge clk) begin
      if (rand_mode) begin
         inst_rvalid = 1'($urandom);
         inst_rdata  = $urandom;
         bus_cnt     = 0;
      end else if (!rst) begin
         inst_rvalid = 1'b0;
         bus_cnt     = 0;
      end else begin
         inst_rvalid = 1'b0;
         if (bus_cnt > 0) begin
            bus_cnt = bus_cnt - 1;
            if (bus_cnt == 0) begin
               inst_rvalid = 1'b1;
               inst_rdata  = bus_data;
            end
         end
         if (inst_req && inst_ack) begin
            bus_cnt  = bus_delay;
            bus_data = use_override ? override_data : inst_addr;
         end
      end
   end

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0;
      rand_mode = 1'b1;
      for (int i = 0; i < 3; i++) begin
         stall         = 6'($urandom);
         branch_flag_i = 1'($urandom);
         branch_target = $urandom;
         flush_i       = 1'($urandom);
         new_pc_i      = $urandom;
         ack_en        = 1'($urandom);
         step();
         checks++;
         if (inst_req !== 1'b0 || if_pc !== 32'd0 || if_inst !== 32'd0 || stallreq !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs cyc%0d: req=%b pc=%h inst=%h stallreq=%b, expected 0/0/0/1",
                     i, inst_req, if_pc, if_inst, stallreq);
         end
      end
      stall = 6'd0; branch_flag_i = 1'b0; branch_target = 32'd0;
      flush_i = 1'b0; new_pc_i = 32'd0; ack_en = 1'b1;
      rand_mode = 1'b0;
      rst = 1'b1;
      checks++;
      if (inst_req !== 1'b0) begin
         errors++;
         $display("FAIL req_before_first_edge: got %b expected 0", inst_req);
      end
      step();
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL first_req: req=%b addr=%h expected 1/00000000", inst_req, inst_addr);
      end
   endtask

   task automatic test_stream;
      logic [31:0] exp_pc;
      for (int i = 0; i < 12; i++) begin
         step();
         exp_pc = 32'(4 * (i / 3));
         checks++;
         if (i % 3 == 1) begin
            if (if_pc !== exp_pc || if_inst !== exp_pc || stallreq !== 1'b0) begin
               errors++;
               $display("FAIL stream_valid cyc%0d: pc=%h inst=%h stallreq=%b expected %h/%h/0",
                        i, if_pc, if_inst, stallreq, exp_pc, exp_pc);
            end
         end else begin
            if (if_pc !== 32'd0 || if_inst !== 32'd0 || stallreq !== 1'b1) begin
               errors++;
               $display("FAIL stream_idle cyc%0d: pc=%h inst=%h stallreq=%b expected 0/0/1",
                        i, if_pc, if_inst, stallreq);
            end
         end
         if (i % 3 == 2) begin
            checks++;
            if (inst_req !== 1'b1 || inst_addr !== exp_pc + 32'd4) begin
               errors++;
               $display("FAIL stream_req cyc%0d: req=%b addr=%h expected 1/%h",
                        i, inst_req, inst_addr, exp_pc + 32'd4);
            end
         end
      end
   endtask

   // Enters in S_REQ at 0x10 (delay slot); branch resolves while the slot is presented.
   task automatic test_branch;
      step(); step();
      checks++;
      if (if_pc !== 32'h10 || stallreq !== 1'b0) begin
         errors++;
         $display("FAIL branch_slot: pc=%h stallreq=%b expected 00000010/0", if_pc, stallreq);
      end
      branch_flag_i = 1'b1; branch_target = 32'h100;
      step();
      branch_flag_i = 1'b0; branch_target = 32'h0;
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h100) begin
         errors++;
         $display("FAIL branch_target_req: req=%b addr=%h expected 1/00000100", inst_req, inst_addr);
      end
      step(); step();
      checks++;
      if (if_pc !== 32'h100 || if_inst !== 32'h100) begin
         errors++;
         $display("FAIL branch_target_valid: pc=%h inst=%h expected 00000100", if_pc, if_inst);
      end
      step();
      checks++;
      if (inst_addr !== 32'h104) begin
         errors++;
         $display("FAIL branch_seq_req: addr=%h expected 00000104", inst_addr);
      end
      step(); step();
      checks++;
      if (if_pc !== 32'h104) begin
         errors++;
         $display("FAIL branch_seq_valid: pc=%h expected 00000104", if_pc);
      end
   endtask

   // Enters in S_VALID at 0x104.
   task automatic test_stall;
      stall = 6'b000011;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if (if_pc !== 32'h104 || if_inst !== 32'h104 || inst_req !== 1'b0 || stallreq !== 1'b0) begin
            errors++;
            $display("FAIL stall_hold cyc%0d: pc=%h inst=%h req=%b stallreq=%b expected 104/104/0/0",
                     i, if_pc, if_inst, inst_req, stallreq);
         end
      end
      stall = 6'd0;
      step();
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h108) begin
         errors++;
         $display("FAIL stall_release: req=%b addr=%h expected 1/00000108", inst_req, inst_addr);
      end
   endtask

   // Enters in S_REQ at 0x108; one-cycle branch pulse while the slot read is pending.
   task automatic test_branch_wait;
      step();
      branch_flag_i = 1'b1; branch_target = 32'h200;
      step();
      branch_flag_i = 1'b0; branch_target = 32'h0;
      checks++;
      if (if_pc !== 32'h108 || if_inst !== 32'h108) begin
         errors++;
         $display("FAIL brwait_slot: pc=%h inst=%h expected 00000108", if_pc, if_inst);
      end
      step();
      checks++;
      if (inst_addr !== 32'h200) begin
         errors++;
         $display("FAIL brwait_target_req: addr=%h expected 00000200", inst_addr);
      end
      step(); step();
      checks++;
      if (if_pc !== 32'h200) begin
         errors++;
         $display("FAIL brwait_target_valid: pc=%h expected 00000200", if_pc);
      end
      step();
      checks++;
      if (inst_addr !== 32'h204) begin
         errors++;
         $display("FAIL brwait_after: addr=%h expected 00000204", inst_addr);
      end
   endtask

   // Enters in S_REQ at 0x204; flush while the read is outstanding, late rvalid carries DEADBEEF.
   task automatic test_flush;
      bus_delay = 3; use_override = 1'b1; override_data = 32'hDEADBEEF;
      step();
      flush_i = 1'b1; new_pc_i = 32'h180;
      step();
      flush_i = 1'b0; new_pc_i = 32'h0;
      bus_delay = 1; use_override = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (inst_req !== 1'b0 || stallreq !== 1'b1 || if_inst !== 32'd0) begin
            errors++;
            $display("FAIL flush_drop cyc%0d: req=%b stallreq=%b inst=%h expected 0/1/0",
                     i, inst_req, stallreq, if_inst);
         end
         step();
      end
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h180 || if_inst !== 32'd0) begin
         errors++;
         $display("FAIL flush_req: req=%b addr=%h inst=%h expected 1/00000180/0",
                  inst_req, inst_addr, if_inst);
      end
      step(); step();
      checks++;
      if (if_pc !== 32'h180 || if_inst !== 32'h180) begin
         errors++;
         $display("FAIL flush_valid: pc=%h inst=%h expected 00000180", if_pc, if_inst);
      end
      step();
   endtask

   // Enters in S_REQ at 0x184; reset lands while the read is outstanding.
   task automatic test_reset_mid;
      step();
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (inst_req !== 1'b0 || inst_addr !== 32'h0 || if_pc !== 32'd0 || stallreq !== 1'b1) begin
         errors++;
         $display("FAIL midreset_async: req=%b addr=%h pc=%h stallreq=%b expected 0/0/0/1",
                  inst_req, inst_addr, if_pc, stallreq);
      end
      step(); step();
      rst = 1'b1;
      step();
      checks++;
      if (inst_req !== 1'b1 || inst_addr !== 32'h0) begin
         errors++;
         $display("FAIL midreset_restart: req=%b addr=%h expected 1/00000000", inst_req, inst_addr);
      end
      step();
      checks++;
      if (stallreq !== 1'b1 || if_inst !== 32'd0) begin
         errors++;
         $display("FAIL midreset_wait: stallreq=%b inst=%h expected 1/0", stallreq, if_inst);
      end
      step();
      checks++;
      if (if_pc !== 32'h0 || if_inst !== 32'h0 || stallreq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_valid: pc=%h inst=%h stallreq=%b expected 0/0/0",
                  if_pc, if_inst, stallreq);
      end
   endtask

   initial begin
      checks = 0; errors = 0;
      rst = 1'b0; stall = 6'd0; branch_flag_i = 1'b0; branch_target = 32'd0;
      flush_i = 1'b0; new_pc_i = 32'd0; ack_en = 1'b1; rand_mode = 1'b0;
      bus_delay = 1; use_override = 1'b0; override_data = 32'd0;
      test_reset();
      test_stream();
      test_branch();
      test_stall();
      test_branch_wait();
      test_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
